cam_frame_receiver: RTL and testbench

- Receiving end of the camera pixel-word handshake.
- Requests words from the camera (or the sim camera model), captures each delivered BUS_WIDTH word and packs PACK consecutive words into one wide memory word.
- Presents packed words with incrementing addresses on a valid/ready write port that feeds the DDR write path (MIG app front end).
- Marks the last write of each frame and restarts addressing at FRAME_BASE for the next frame.

---
 rtl/cam_frame_receiver.sv | 250 +++++++++++++++++++++++++
 tb/tb_cam_frame_receiver.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_frame_receiver.sv
// cam_frame_receiver
//
// Receiving end of the camera pixel-word handshake. The block asks the
// camera for one word at a time, captures it, and packs PACK consecutive
// words into one wide write word. Each packed word goes out on a
// valid/ready write port with an incrementing address. The last write of
// a frame is tagged, and addressing restarts at FRAME_BASE for the next
// frame.
//
// Parameters
//   BUS_WIDTH  - camera data word width in bits
//   PACK       - camera words per write word (>= 1)
//   ADDR_WIDTH - write address width
//   ADDR_STEP  - address increment per write word
//   FRAME_BASE - address of the first write word of every frame
//   TIMEOUT    - cycles allowed in REQ or WAIT before the transaction is
//                abandoned (>= 1)
//
// Ports
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   capture_en    in   allows new camera requests
//   recieve_ready out  request to the camera
//   in_progress   in   camera acknowledge / transfer pending
//   data          in   camera data word
//   data_valid    in   camera data qualifier
//   frame_end     in   camera frame-end level (may stay high)
//   wr_valid      out  write word available
//   wr_ready      in   downstream accepts the write word
//   wr_data       out  packed word, first captured word in the low slot
//   wr_addr       out  write address
//   wr_last       out  last write word of the frame (qualified by wr_valid)
//   frame_count   out  completed frames, wraps modulo 2^16
//   timeout_err   out  one-cycle pulse when a transaction is abandoned
module cam_frame_receiver #(
    parameter int BUS_WIDTH  = 96,
    parameter int PACK       = 2,
    parameter int ADDR_WIDTH = 28,
    parameter int ADDR_STEP  = 8,
    parameter int FRAME_BASE = 0,
    parameter int TIMEOUT    = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        capture_en,
    output logic                        recieve_ready,
    input  logic                        in_progress,
    input  logic [BUS_WIDTH-1:0]        data,
    input  logic                        data_valid,
    input  logic                        frame_end,
    output logic                        wr_valid,
    input  logic                        wr_ready,
    output logic [BUS_WIDTH*PACK-1:0]   wr_data,
    output logic [ADDR_WIDTH-1:0]       wr_addr,
    output logic                        wr_last,
    output logic [15:0]                 frame_count,
    output logic                        timeout_err
);

    localparam int DATA_W = BUS_WIDTH * PACK;
    localparam int SLOT_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    localparam logic [SLOT_W-1:0]     SLOT_LAST = SLOT_W'(PACK - 1);
    localparam logic [TMO_W-1:0]      TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_BASE = ADDR_WIDTH'(FRAME_BASE);
    localparam logic [ADDR_WIDTH-1:0] ADDR_INC  = ADDR_WIDTH'(ADDR_STEP);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;

    logic [SLOT_W-1:0]   slot_cnt_r;
    logic [SLOT_W-1:0]   slot_cnt_nxt_s;
    logic [DATA_W-1:0]   slots_r;
    logic [DATA_W-1:0]   slots_nxt_s;
    logic                prev_fe_r;
    logic                prev_fe_nxt_s;
    logic [TMO_W-1:0]    tmo_cnt_r;
    logic [TMO_W-1:0]    tmo_cnt_nxt_s;

    logic                rr_nxt_s;
    logic                valid_nxt_s;
    logic [DATA_W-1:0]   data_nxt_s;
    logic [ADDR_WIDTH-1:0] addr_nxt_s;
    logic                last_nxt_s;
    logic [15:0]         fc_nxt_s;
    logic                tmo_err_nxt_s;

    logic                capture_s;
    logic                fe_rise_s;
    logic                pack_done_s;
    int                  slot_idx_s;
    logic [DATA_W-1:0]   slots_wr_s;
    logic [DATA_W-1:0]   pack_s;

    // Data is only trusted once the camera has dropped its acknowledge;
    // data_valid seen during REQ or while in_progress is high is ignored.
    assign capture_s   = (state_r == ST_WAIT) && !in_progress && data_valid;
    // frame_end is a level that may stay high, so only its rising edge
    // across captures marks the end of a frame.
    assign fe_rise_s   = frame_end & ~prev_fe_r;
    assign pack_done_s = (slot_cnt_r == SLOT_LAST) || fe_rise_s;
    assign slot_idx_s  = int'(slot_cnt_r);

    // Slot write-back and packed word: slots above the current one are
    // zeroed so a short (frame-end) pack never leaks stale words.
    always_comb begin
        slots_wr_s = slots_r;
        pack_s     = {DATA_W{1'b0}};
        for (int i = 0; i < PACK; i++) begin
            if (i == slot_idx_s) begin
                slots_wr_s[i*BUS_WIDTH +: BUS_WIDTH] = data;
                pack_s[i*BUS_WIDTH +: BUS_WIDTH]     = data;
            end else if (i < slot_idx_s) begin
                pack_s[i*BUS_WIDTH +: BUS_WIDTH]     = slots_r[i*BUS_WIDTH +: BUS_WIDTH];
            end else begin
                pack_s[i*BUS_WIDTH +: BUS_WIDTH]     = {BUS_WIDTH{1'b0}};
            end
        end
    end

    // Next-state and next-output logic of the request/capture/write FSM.
    always_comb begin
        state_nxt_s    = state_r;
        rr_nxt_s       = recieve_ready;
        valid_nxt_s    = wr_valid;
        data_nxt_s     = wr_data;
        addr_nxt_s     = wr_addr;
        last_nxt_s     = wr_last;
        fc_nxt_s       = frame_count;
        tmo_err_nxt_s  = 1'b0;
        slot_cnt_nxt_s = slot_cnt_r;
        slots_nxt_s    = slots_r;
        prev_fe_nxt_s  = prev_fe_r;
        tmo_cnt_nxt_s  = tmo_cnt_r;

        case (state_r)
            ST_IDLE: begin
                // A pending write word is backpressure: no new request.
                if (capture_en && !wr_valid) begin
                    state_nxt_s   = ST_REQ;
                    rr_nxt_s      = 1'b1;
                    tmo_cnt_nxt_s = {TMO_W{1'b0}};
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end

            ST_REQ: begin
                if (in_progress) begin
                    state_nxt_s   = ST_WAIT;
                    rr_nxt_s      = 1'b0;
                    tmo_cnt_nxt_s = {TMO_W{1'b0}};
                end else if (tmo_cnt_r == TMO_LAST) begin
                    state_nxt_s   = ST_IDLE;
                    rr_nxt_s      = 1'b0;
                    tmo_err_nxt_s = 1'b1;
                end else begin
                    tmo_cnt_nxt_s = tmo_cnt_r + TMO_W'(1);
                end
            end

            ST_WAIT: begin
                if (capture_s) begin
                    slots_nxt_s   = slots_wr_s;
                    prev_fe_nxt_s = frame_end;
                    if (pack_done_s) begin
                        state_nxt_s    = ST_OUT;
                        valid_nxt_s    = 1'b1;
                        data_nxt_s     = pack_s;
                        last_nxt_s     = fe_rise_s;
                        slot_cnt_nxt_s = {SLOT_W{1'b0}};
                    end else begin
                        state_nxt_s    = ST_IDLE;
                        slot_cnt_nxt_s = slot_cnt_r + SLOT_W'(1);
                    end
                end else if (tmo_cnt_r == TMO_LAST) begin
                    // Abandon the transfer; packed slots and address survive.
                    state_nxt_s   = ST_IDLE;
                    rr_nxt_s      = 1'b0;
                    tmo_err_nxt_s = 1'b1;
                end else begin
                    tmo_cnt_nxt_s = tmo_cnt_r + TMO_W'(1);
                end
            end

            ST_OUT: begin
                if (wr_ready) begin
                    state_nxt_s = ST_IDLE;
                    valid_nxt_s = 1'b0;
                    last_nxt_s  = 1'b0;
                    if (wr_last) begin
                        addr_nxt_s = ADDR_BASE;
                        fc_nxt_s   = frame_count + 16'd1;
                    end else begin
                        addr_nxt_s = wr_addr + ADDR_INC;
                    end
                end else begin
                    state_nxt_s = ST_OUT;
                end
            end

            default: begin
                state_nxt_s = ST_IDLE;
                rr_nxt_s    = 1'b0;
                valid_nxt_s = 1'b0;
                last_nxt_s  = 1'b0;
            end
        endcase
    end

    // State, pack storage and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            recieve_ready <= 1'b0;
            wr_valid      <= 1'b0;
            wr_data       <= {DATA_W{1'b0}};
            wr_addr       <= ADDR_BASE;
            wr_last       <= 1'b0;
            frame_count   <= 16'd0;
            timeout_err   <= 1'b0;
            slot_cnt_r    <= {SLOT_W{1'b0}};
            slots_r       <= {DATA_W{1'b0}};
            prev_fe_r     <= 1'b0;
            tmo_cnt_r     <= {TMO_W{1'b0}};
        end else begin
            state_r       <= state_nxt_s;
            recieve_ready <= rr_nxt_s;
            wr_valid      <= valid_nxt_s;
            wr_data       <= data_nxt_s;
            wr_addr       <= addr_nxt_s;
            wr_last       <= last_nxt_s;
            frame_count   <= fc_nxt_s;
            timeout_err   <= tmo_err_nxt_s;
            slot_cnt_r    <= slot_cnt_nxt_s;
            slots_r       <= slots_nxt_s;
            prev_fe_r     <= prev_fe_nxt_s;
            tmo_cnt_r     <= tmo_cnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_cam_frame_receiver.sv
// Testbench for cam_frame_receiver: a behavioural camera, a scoreboard of
// expected write words filled as camera words are queued, and a write-port
// monitor that pops and compares on every accepted write.
module tb_cam_frame_receiver;

    localparam int BW   = 24;
    localparam int PK   = 2;
    localparam int DW   = BW * PK;
    localparam int AW   = 28;
    localparam int STEP = 8;
    localparam int TMO  = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           capture_en;
    logic           recieve_ready;
    logic           in_progress;
    logic [BW-1:0]  data;
    logic           data_valid;
    logic           frame_end;
    logic           wr_valid;
    logic           wr_ready;
    logic [DW-1:0]  wr_data;
    logic [AW-1:0]  wr_addr;
    logic           wr_last;
    logic [15:0]    frame_count;
    logic           timeout_err;

    cam_frame_receiver #(
        .BUS_WIDTH(BW), .PACK(PK), .ADDR_WIDTH(AW),
        .ADDR_STEP(STEP), .FRAME_BASE(0), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .capture_en(capture_en),
        .recieve_ready(recieve_ready), .in_progress(in_progress),
        .data(data), .data_valid(data_valid), .frame_end(frame_end),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .wr_addr(wr_addr), .wr_last(wr_last), .frame_count(frame_count),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [BW-1:0] word; logic fe; } cam_t;
    typedef struct { logic [DW-1:0] data; logic [AW-1:0] addr; logic last; logic [15:0] fc; } exp_t;

    cam_t  cam_q[$];
    exp_t  sb_q[$];
    int    n_vec = 0;
    int    n_bad = 0;
    logic  cam_stall = 1'b0;
    logic  cam_mute  = 1'b0;

    // Reference model of the packing state
    logic [BW-1:0] m_slots [PK];
    int            m_cnt;
    logic          m_prev_fe;
    logic [AW-1:0] m_addr;
    logic [15:0]   m_fc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt     = 0;
        m_prev_fe = 1'b0;
        m_addr    = {AW{1'b0}};
        m_fc      = 16'd0;
    endtask

    // Queue one camera word and record the write it should produce.
    task automatic push_word(input logic [BW-1:0] w, input logic fe);
        cam_t c;
        exp_t e;
        logic last;
        c.word = w;
        c.fe   = fe;
        cam_q.push_back(c);
        last      = fe & ~m_prev_fe;
        m_prev_fe = fe;
        m_slots[m_cnt] = w;
        if (m_cnt == PK - 1 || last) begin
            e.data = {DW{1'b0}};
            for (int i = 0; i <= m_cnt; i++) e.data[i*BW +: BW] = m_slots[i];
            e.addr = m_addr;
            e.last = last;
            e.fc   = m_fc;
            sb_q.push_back(e);
            if (last) begin
                m_addr = {AW{1'b0}};
                m_fc   = m_fc + 16'd1;
            end else begin
                m_addr = m_addr + AW'(STEP);
            end
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic wait_rr(input string tag, input logic level, input int budget);
        int n = 0;
        while (recieve_ready !== level && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(recieve_ready), 64'(level));
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check(tag, 64'(sb_q.size()), 64'd0);
        #1 capture_en = 1'b0;
        repeat (3 * TMO + 10) @(posedge clk);
        #1;
    endtask

    // Behavioural camera: registered response to recieve_ready.
    initial begin
        logic s_rr;
        logic s_err;
        cam_t c;
        in_progress = 1'b0;
        data_valid  = 1'b0;
        data        = {BW{1'b0}};
        frame_end   = 1'b0;
        forever begin
            @(negedge clk);
            s_rr  = recieve_ready;
            s_err = timeout_err;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                in_progress = 1'b0;
                data_valid  = 1'b0;
                frame_end   = 1'b0;
            end else begin
                data_valid = 1'b0;
                if (s_err) begin
                    in_progress = 1'b0;
                end else if (s_rr) begin
                    if (!cam_mute) in_progress = 1'b1;
                end else if (in_progress && !cam_stall && cam_q.size() > 0) begin
                    c           = cam_q.pop_front();
                    in_progress = 1'b0;
                    data_valid  = 1'b1;
                    data        = c.word;
                    frame_end   = c.fe;
                end
            end
        end
    end

    // Write-port monitor: every accepted word must match the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && wr_valid && wr_ready) begin
            check("write_expected", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("wr_data", 64'(wr_data), 64'(e.data));
                check("wr_addr", 64'(wr_addr), 64'(e.addr));
                check("wr_last", 64'(wr_last), 64'(e.last));
                check("frame_count", 64'(frame_count), 64'(e.fc));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n      = 1'b1;
        capture_en = 1'b0;
        wr_ready   = 1'b1;
        model_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rr", 64'(recieve_ready), 64'd0);
        check("rst_valid", 64'(wr_valid), 64'd0);
        check("rst_last", 64'(wr_last), 64'd0);
        check("rst_tmo", 64'(timeout_err), 64'd0);
        check("rst_data", 64'(wr_data), 64'd0);
        check("rst_addr", 64'(wr_addr), 64'd0);
        check("rst_fc", 64'(frame_count), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Packing, odd-count frame end, frame_end held high
        push_word(24'h010203, 1'b0);
        push_word(24'h040506, 1'b0);
        push_word(24'h070809, 1'b1);
        push_word(24'h111111, 1'b1);
        push_word(24'h222222, 1'b1);
        push_word(24'h333333, 1'b0);
        push_word(24'h444444, 1'b1);
        capture_en = 1'b1;
        drain("frames_drain", 500);

        // Backpressure: write held 20 cycles
        wr_ready = 1'b0;
        push_word(24'ha00001, 1'b0);
        push_word(24'ha00002, 1'b0);
        push_word(24'ha00003, 1'b0);
        push_word(24'ha00004, 1'b0);
        capture_en = 1'b1;
        n = 0;
        while (wr_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", 64'(wr_valid), 64'd1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("bp_valid", 64'(wr_valid), 64'd1);
            check("bp_data", 64'(wr_data), 64'(sb_q[0].data));
            check("bp_addr", 64'(wr_addr), 64'(sb_q[0].addr));
            check("bp_rr", 64'(recieve_ready), 64'd0);
        end
        @(posedge clk);
        #1 wr_ready = 1'b1;
        drain("bp_drain", 300);

        // capture_en dropped while WAIT is pending
        cam_stall = 1'b1;
        push_word(24'h5a5a5a, 1'b0);
        push_word(24'ha5a5a5, 1'b0);
        capture_en = 1'b1;
        wait_rr("ce_req", 1'b1, 50);
        wait_rr("ce_wait", 1'b0, 50);
        capture_en = 1'b0;
        cam_stall  = 1'b0;
        n = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (recieve_ready === 1'b1) n++;
        end
        check("ce_no_request", 64'(n), 64'd0);
        check("ce_no_write", 64'(wr_valid), 64'd0);
        capture_en = 1'b1;
        drain("ce_drain", 300);

        // Reset while WAIT is pending with one slot filled
        push_word(24'h0c0c0c, 1'b0);
        capture_en = 1'b1;
        wait_rr("rs_req1", 1'b1, 50);
        wait_rr("rs_wait1", 1'b0, 50);
        wait_rr("rs_req2", 1'b1, 50);
        wait_rr("rs_wait2", 1'b0, 50);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        capture_en = 1'b0;
        #1;
        check("mid_rst_rr", 64'(recieve_ready), 64'd0);
        check("mid_rst_valid", 64'(wr_valid), 64'd0);
        check("mid_rst_data", 64'(wr_data), 64'd0);
        check("mid_rst_addr", 64'(wr_addr), 64'd0);
        check("mid_rst_last", 64'(wr_last), 64'd0);
        check("mid_rst_fc", 64'(frame_count), 64'd0);
        check("mid_rst_tmo", 64'(timeout_err), 64'd0);
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        push_word(24'h0b0b0b, 1'b0);
        push_word(24'h0c0d0e, 1'b0);
        capture_en = 1'b1;
        drain("rs_drain", 300);

        // REQ timeout: camera never acknowledges
        cam_mute   = 1'b1;
        capture_en = 1'b1;
        wait_rr("to_req", 1'b1, 50);
        n = 0;
        while (recieve_ready === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("to_req_cycles", 64'(n), 64'(TMO));
        check("to_err_pulse", 64'(timeout_err), 64'd1);
        @(negedge clk);
        check("to_rerequest", 64'(recieve_ready), 64'd1);
        check("to_err_single", 64'(timeout_err), 64'd0);
        capture_en = 1'b0;
        repeat (2 * TMO + 10) @(negedge clk);
        cam_mute = 1'b0;
        check("to_no_write", 64'(wr_valid), 64'd0);

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
